// File: rtl/pid_ctrl_gen.sv
// Balance PID controller: saturated P + I + D sum behind a two-stage pipeline, with
// a clamping integrator, integrator bleed while the rider is off, and a soft-start ramp.
module pid_ctrl_gen #(
    parameter int ERR_W       = 10,
    parameter int P_GAIN      = 9,
    parameter int I_SHIFT     = 6,
    parameter int D_SHIFT     = 6,
    parameter int INT_W       = 18,
    parameter int OUT_W       = 12,
    parameter int SS_W        = 27,
    parameter int SS_BITS     = 8,
    parameter int BLEED_SHIFT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vld,
    input  logic signed [15:0]      ptch,
    input  logic signed [15:0]      ptch_rt,
    input  logic                    pwr_up,
    input  logic                    rider_off,
    output logic signed [OUT_W-1:0] PID_cntrl,
    output logic                    cntrl_vld,
    output logic [SS_BITS-1:0]      ss_tmr,
    output logic [1:0]              state,
    output logic                    int_sat
);
    typedef enum logic [1:0] {OFF = 2'd0, RAMP = 2'd1, RUN = 2'd2, BLEED = 2'd3} state_t;

    localparam int WMAX0 = (INT_W > ERR_W + 6) ? INT_W : ERR_W + 6;
    localparam int SUM_W = ((WMAX0 > 17) ? WMAX0 : 17) + 2;
    localparam int ERR_MAX = 2**(ERR_W-1) - 1;
    localparam int ERR_MIN = -(2**(ERR_W-1));
    localparam logic signed [INT_W-1:0] INT_MAX   = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic signed [INT_W-1:0] INT_MIN   = {1'b1, {(INT_W-1){1'b0}}};
    localparam logic signed [INT_W-1:0] BLEED_LIM = INT_W'(2**BLEED_SHIFT);
    localparam logic signed [SUM_W-1:0] OUT_MAX   = SUM_W'(2**(OUT_W-1) - 1);
    localparam logic signed [SUM_W-1:0] OUT_MIN   = -SUM_W'(2**(OUT_W-1));

    state_t                  st_q, st_d;
    logic [SS_W-1:0]         tmr_q, tmr_d, tmr_inc;
    logic                    tmr_sat, inc_sat, take;
    logic signed [ERR_W-1:0] err_c, err_q;
    logic signed [15:0]      d_c, d_q;
    logic                    s1_vld;
    logic signed [INT_W-1:0] integ_q, integ_clamped, integ_bled;
    logic signed [INT_W:0]   integ_sum;
    logic                    integ_ovf;
    logic signed [SUM_W-1:0] p_term, i_term, d_term, sum_c;
    logic signed [OUT_W-1:0] sat_c, lim_c, out_c;

    assign state   = st_q;
    assign ss_tmr  = tmr_q[SS_W-1 -: SS_BITS];
    assign tmr_inc = tmr_q + SS_W'(1);
    assign inc_sat = &tmr_inc[SS_W-1 -: SS_BITS];
    assign tmr_sat = &ss_tmr;

    always_comb begin
        st_d  = st_q;
        tmr_d = tmr_q;
        if (!pwr_up) begin
            st_d  = OFF;
            tmr_d = '0;
        end else begin
            case (st_q)
                OFF: begin
                    st_d  = RAMP;
                    tmr_d = '0;
                end
                RAMP: begin
                    if (rider_off) begin
                        st_d = BLEED;
                    end else begin
                        tmr_d = tmr_inc;
                        if (inc_sat) st_d = RUN;
                    end
                end
                RUN:     if (rider_off) st_d = BLEED;
                BLEED:   if (!rider_off) st_d = tmr_sat ? RUN : RAMP;
                default: st_d = OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= OFF;
            tmr_q <= '0;
        end else begin
            st_q  <= st_d;
            tmr_q <= tmr_d;
        end
    end

    // vld is a one-cycle strobe with no backpressure; each accepted strobe yields
    // exactly one cntrl_vld pulse two cycles later unless power drops or reset hits.
    assign take = vld && pwr_up && (st_q != OFF);

    always_comb begin
        if (int'(ptch) > ERR_MAX)      err_c = ERR_W'(ERR_MAX);
        else if (int'(ptch) < ERR_MIN) err_c = ERR_W'(ERR_MIN);
        else                           err_c = ptch[ERR_W-1:0];
        d_c = -(ptch_rt >>> D_SHIFT);
        integ_sum = $signed({integ_q[INT_W-1], integ_q})
                  + $signed({{(INT_W+1-ERR_W){err_c[ERR_W-1]}}, err_c});
        integ_ovf = integ_sum[INT_W] ^ integ_sum[INT_W-1];
        if (integ_ovf) integ_clamped = integ_sum[INT_W] ? INT_MIN : INT_MAX;
        else           integ_clamped = integ_sum[INT_W-1:0];
        // Snap small magnitudes to zero so arithmetic-shift rounding cannot stick at -1.
        if ((integ_q < BLEED_LIM) && (integ_q > -BLEED_LIM)) integ_bled = '0;
        else integ_bled = integ_q - (integ_q >>> BLEED_SHIFT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            err_q   <= '0;
            d_q     <= '0;
            integ_q <= '0;
            int_sat <= 1'b0;
        end else begin
            s1_vld <= take;
            if (take) begin
                err_q <= err_c;
                d_q   <= d_c;
            end
            if (!pwr_up || st_q == OFF) begin
                integ_q <= '0;
            end else if (st_q == BLEED) begin
                integ_q <= integ_bled;
            end else if (vld && !rider_off) begin
                integ_q <= integ_clamped;
                int_sat <= integ_ovf;
            end
        end
    end

    always_comb begin
        p_term = SUM_W'(err_q) * SUM_W'(P_GAIN);
        i_term = SUM_W'(integ_q >>> I_SHIFT);
        d_term = SUM_W'(d_q);
        sum_c  = p_term + i_term + d_term;
        if (sum_c > OUT_MAX)      sat_c = OUT_MAX[OUT_W-1:0];
        else if (sum_c < OUT_MIN) sat_c = OUT_MIN[OUT_W-1:0];
        else                      sat_c = sum_c[OUT_W-1:0];
        lim_c = $signed(OUT_W'(ss_tmr) << (OUT_W-1-SS_BITS));
        if (tmr_sat)             out_c = sat_c;
        else if (sat_c > lim_c)  out_c = lim_c;
        else if (sat_c < -lim_c) out_c = -lim_c;
        else                     out_c = sat_c;
    end

    always_ff @(posedge clk) begin
        if (rst || !pwr_up || st_q == OFF) begin
            PID_cntrl <= '0;
            cntrl_vld <= 1'b0;
        end else begin
            cntrl_vld <= s1_vld;
            if (st_q == BLEED) PID_cntrl <= '0;
            else if (s1_vld)   PID_cntrl <= out_c;
        end
    end
endmodule

// File: doc/pid_ctrl_gen.md
Name: pid_ctrl_gen

Overview:
Parametrised next-generation balance PID controller for the inertial loop. It takes the pitch and pitch-rate samples and produces a saturated signed control word. Compared with the current controller it adds:
- configurable widths, gain and shifts;
- a registered 2-stage pipeline with an output-valid strobe;
- a clamping (not holding) anti-windup integrator;
- an integrator bleed-down when the rider steps off;
- a soft-start limit that ramps the output magnitude under a 4-state FSM.

Parameters:
ERR_W, 10, saturated pitch-error width (signed)
P_GAIN, 9, proportional gain (unsigned integer, 5 bits max)
I_SHIFT, 6, integrator right-shift (arithmetic) forming I term
D_SHIFT, 6, pitch-rate right-shift (arithmetic) forming D term
INT_W, 18, integrator width (signed)
OUT_W, 12, control output width (signed)
SS_W, 27, soft-start timer width
SS_BITS, 8, timer MSBs exported as ss_tmr (SS_BITS <= OUT_W-1)
BLEED_SHIFT, 4, integrator decay shift while rider off

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
vld  input  1  new sensor sample valid, single-cycle strobe
ptch  input  16  signed pitch
ptch_rt  input  16  signed pitch rate
pwr_up  input  1  power enabled
rider_off  input  1  no rider detected
PID_cntrl  output  OUT_W  signed control word, registered
cntrl_vld  output  1  1-cycle strobe: PID_cntrl updated
ss_tmr  output  SS_BITS  timer[SS_W-1:SS_W-SS_BITS]
state  output  2  OFF=0, RAMP=1, RUN=2, BLEED=3
int_sat  output  1  integrator clamped on last update (sticky until next vld)

Behaviour:
- Reset (rst=1 at posedge clk): state=OFF; timer, integrator and all pipeline registers cleared. PID_cntrl=0, cntrl_vld=0, ss_tmr=0, int_sat=0.
- Event priority per cycle: rst > !pwr_up > rider_off > vld.
- FSM:
  - OFF: timer=0, integrator=0. Goes to RAMP when pwr_up=1.
  - RAMP: timer+1 per cycle. Goes to RUN on the cycle the timer reaches all-ones in the top SS_BITS; the timer then holds.
  - RUN: timer holds.
  - RAMP/RUN go to BLEED when rider_off=1.
  - BLEED: timer holds. Goes to RUN when rider_off=0 and the timer is saturated, else to RAMP.
  - Any state goes to OFF the cycle after pwr_up=0. The timer is cleared on entry to OFF.
- Stage 1 (registered on vld, in any state other than OFF):
  - err_sat = ptch saturated to signed ERR_W: max 2^(ERR_W-1)-1, min -2^(ERR_W-1).
  - d_reg = -(ptch_rt >>> D_SHIFT).
  - In RAMP/RUN, the integrator updates to sat_INT_W(integ + sext(err_sat)). Clamp at ±limits; int_sat=1 if clamped.
- Stage 2 (cycle after stage 1):
  - sum = err_sat*P_GAIN + (integ >>> I_SHIFT) + d_reg, computed at full width with no overflow.
  - Saturate sum to OUT_W.
  - Soft-start clamp: |out| <= ss_tmr << (OUT_W-1-SS_BITS), bypassed when ss_tmr is all ones.
  - Register the result to PID_cntrl and pulse cntrl_vld.
- Latency: vld at cycle N gives cntrl_vld=1 at cycle N+2. Back-to-back vld gives back-to-back cntrl_vld.
- BLEED:
  - Each cycle, integ <= integ - (integ >>> BLEED_SHIFT).
  - If |integ| < 2^BLEED_SHIFT, integ <= 0. This prevents a stuck -1 from arithmetic-shift rounding.
  - The PID_cntrl register is forced to 0. cntrl_vld still pulses for in-flight samples, carrying value 0.
- OFF: PID_cntrl forced 0. In-flight pipeline contents are discarded and no cntrl_vld is raised.
- Reset mid-pipeline: no cntrl_vld is produced for a sample captured before reset.
- Width rules: all arithmetic is signed. D negation of the most-negative shifted value cannot overflow, since the shift is >= 1.

Test Plan:
1. Pipeline latency and arithmetic (SS_W=11; drive pwr_up=1 for 2040 cycles to reach RUN; integ=0): vld with ptch=100, ptch_rt=640 -> integ=100; 2 cycles later cntrl_vld=1, PID_cntrl=900+1-10=891.
2. Error and output saturation: ptch=16'h7FFF, ptch_rt=16'h8000 in RUN -> err_sat=511; P=4599 plus D=+512 -> PID_cntrl=2047. ptch=16'h8000 -> err_sat=-512, PID_cntrl=-2048 (12'h800).
3. Integrator clamp: 257 vld with ptch=16'h7FFF -> integ=131071 (not wrapped), int_sat=1 on the last update only.
4. Soft start (SS_W=11): in RAMP with ss_tmr=10 and P-only demand 900 -> PID_cntrl=80. Once ss_tmr=255 -> unclamped 900; state=RUN.
5. Bleed: integ=1600, rider_off=1 -> state=BLEED; integ=1500 next cycle; integ=12 -> 0; PID_cntrl=0. Deassert rider_off -> RUN.
6. Power drop and reset: pwr_up=0 mid-RAMP with a vld in flight -> state=OFF next cycle, ss_tmr=0, no cntrl_vld. rst=1 for one cycle in RUN -> all outputs 0, state=OFF.
